// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared types and constants for the interrupt controller
package irq_pkg;

  typedef enum logic [1:0] {IRQ_IDLE, IRQ_HANDLER, IRQ_ACK} irq_state_t;

  localparam logic [31:0] IRQ_CAUSE_BASE = 32'h8000_0010;
  localparam int          MIE_IRQ_LSB    = 16;

  // Index width that stays legal for a single-line configuration.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - IRQ lines, core trap controls and trap/ack outputs
interface irq_controller_if #(
  parameter int N_IRQ = 16
) ();

  logic [N_IRQ-1:0] irq_req_i;
  logic [31:0]      mie_i;
  logic             exception_i;
  logic             mret_i;
  logic             stall_i;
  logic             irq_o;
  logic [31:0]      irq_cause_o;
  logic [N_IRQ-1:0] irq_ret_o;
  logic             busy_o;

  modport master (
    output irq_req_i, mie_i, exception_i, mret_i, stall_i,
    input  irq_o, irq_cause_o, irq_ret_o, busy_o
  );

  modport slave (
    input  irq_req_i, mie_i, exception_i, mret_i, stall_i,
    output irq_o, irq_cause_o, irq_ret_o, busy_o
  );

endinterface

// File: rtl/irq_priority_encoder.sv
// rtl/irq_priority_encoder.sv - fixed-priority encoder, lowest pending index wins
module irq_priority_encoder
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16,
  parameter int IDX_W = idx_width(N_IRQ)
) (
  input  logic [N_IRQ-1:0] pending,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N_IRQ-1:0] onehot
);

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    valid  = 1'b0;
    index  = '0;
    onehot = '0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (pending[k]) begin
        valid     = 1'b1;
        index     = IDX_W'(k);
        onehot    = '0;
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - IRQ arbitration against mie, trap request, handler tracking and mret ack
module irq_controller
  import irq_pkg::*;
#(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  irq_controller_if.slave  bus
);

  localparam int IDX_W = idx_width(N_IRQ);

  irq_state_t       state, state_next;
  logic             exc_h;
  logic [IDX_W-1:0] irq_idx;

  logic [N_IRQ-1:0] pending;
  logic             enc_valid;
  logic [IDX_W-1:0] enc_index;
  logic [N_IRQ-1:0] enc_onehot;
  logic             take;
  logic             unused_sig;

  assign pending = bus.irq_req_i & bus.mie_i[MIE_IRQ_LSB +: N_IRQ];

  irq_priority_encoder #(.N_IRQ(N_IRQ), .IDX_W(IDX_W)) u_enc (
    .pending (pending),
    .valid   (enc_valid),
    .index   (enc_index),
    .onehot  (enc_onehot)
  );

  // A same-cycle exception always beats a pending interrupt.
  assign take = (state == IRQ_IDLE) & enc_valid & ~bus.exception_i & ~exc_h
              & ~bus.stall_i & ~rst_i;

  always_comb begin
    state_next = state;
    case (state)
      IRQ_IDLE:    if (take) state_next = IRQ_HANDLER;
      IRQ_HANDLER: if (bus.mret_i && !exc_h) state_next = IRQ_ACK;
      IRQ_ACK:     state_next = IRQ_IDLE;
      default:     state_next = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IRQ_IDLE;
      exc_h   <= 1'b0;
      irq_idx <= '0;
    end else begin
      state <= state_next;
      if (take) irq_idx <= enc_index;
      // The first mret after an exception only unwinds the exception level.
      if (bus.exception_i)           exc_h <= 1'b1;
      else if (bus.mret_i && exc_h)  exc_h <= 1'b0;
    end
  end

  assign bus.irq_o       = take;
  assign bus.irq_cause_o = take ? (IRQ_CAUSE_BASE + 32'(enc_index)) : 32'h0;
  assign bus.irq_ret_o   = (state == IRQ_ACK) ? (N_IRQ'(1) << irq_idx) : '0;
  assign bus.busy_o      = (state == IRQ_HANDLER);

  assign unused_sig = ^{bus.mie_i, enc_onehot};

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - scoreboard bench for irq_controller
module tb_irq_controller;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  irq_controller_if #(.N_IRQ(N)) bus ();

  irq_controller #(.N_IRQ(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  typedef struct {
    bit          is_ret;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_irq(input logic [31:0] cause);
    exp_t e;
    e.is_ret = 1'b0;
    e.val    = cause;
    sb.push_back(e);
  endtask

  task automatic push_ret(input logic [31:0] mask);
    exp_t e;
    e.is_ret = 1'b1;
    e.val    = mask;
    sb.push_back(e);
  endtask

  task automatic mret_pulse();
    bus.mret_i = 1'b1;
    step();
    bus.mret_i = 1'b0;
  endtask

  // Every trap request or ack the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.irq_o === 1'b1) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_irq: got cause %h expected no irq", bus.irq_cause_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_ret || bus.irq_cause_o !== e.val) begin
          fails++;
          $display("FAIL irq_cause: got irq cause %h expected %s %h",
                   bus.irq_cause_o, e.is_ret ? "ack" : "irq cause", e.val);
        end
      end
    end
    if (bus.irq_ret_o !== '0) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_ack: got ack %h expected no ack", bus.irq_ret_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (!e.is_ret || 32'(bus.irq_ret_o) !== e.val) begin
          fails++;
          $display("FAIL irq_ret: got ack %h expected %s %h",
                   bus.irq_ret_o, e.is_ret ? "ack" : "irq cause", e.val);
        end
      end
    end
  end

  initial begin
    bus.irq_req_i   = '0;
    bus.mie_i       = '0;
    bus.exception_i = 1'b0;
    bus.mret_i      = 1'b0;
    bus.stall_i     = 1'b0;
    rst = 1'b1;
    step();
    step();
    chk("reset_irq",   32'(bus.irq_o), 32'h0);
    chk("reset_cause", bus.irq_cause_o, 32'h0);
    chk("reset_ret",   32'(bus.irq_ret_o), 32'h0);
    chk("reset_busy",  32'(bus.busy_o), 32'h0);
    rst = 1'b0;

    // Basic interrupt and ack
    bus.mie_i = 32'h0001_0000;
    push_irq(32'h8000_0010);
    bus.irq_req_i = 16'h0001;
    step();
    chk("basic_busy", 32'(bus.busy_o), 32'h1);
    push_ret(32'h1);
    mret_pulse();
    bus.irq_req_i = '0;
    step();
    chk("basic_idle", 32'(bus.busy_o), 32'h0);
    chk("basic_drain", sb.size(), 0);

    // Priority: lowest index wins, then the next one after the ack
    bus.mie_i = 32'h000A_0000;
    push_irq(32'h8000_0011);
    bus.irq_req_i = 16'h000A;
    step();
    push_ret(32'h2);
    mret_pulse();
    bus.irq_req_i = 16'h0008;
    push_irq(32'h8000_0013);
    step();
    step();
    push_ret(32'h8);
    mret_pulse();
    bus.irq_req_i = '0;
    step();
    chk("prio_drain", sb.size(), 0);

    // Masking by mie, stall and a same-cycle exception
    bus.mie_i = 32'h0;
    bus.irq_req_i = 16'h0004;
    step();
    step();
    bus.mie_i = 32'h0004_0000;
    bus.stall_i = 1'b1;
    step();
    step();
    bus.stall_i = 1'b0;
    bus.exception_i = 1'b1;
    step();
    bus.exception_i = 1'b0;
    step();
    chk("mask_exc_busy", 32'(bus.busy_o), 32'h0);
    mret_pulse();
    push_irq(32'h8000_0012);
    step();
    push_ret(32'h4);
    mret_pulse();
    bus.irq_req_i = '0;
    step();
    chk("mask_drain", sb.size(), 0);

    // Exception nested inside the handler; request dropped while in HANDLER
    bus.mie_i = 32'h0001_0000;
    push_irq(32'h8000_0010);
    bus.irq_req_i = 16'h0001;
    step();
    bus.irq_req_i = '0;
    bus.exception_i = 1'b1;
    step();
    bus.exception_i = 1'b0;
    mret_pulse();
    step();
    chk("nest_busy", 32'(bus.busy_o), 32'h1);
    push_ret(32'h1);
    mret_pulse();
    step();
    chk("nest_drain", sb.size(), 0);

    // Reset inside the handler: no ack afterwards
    push_irq(32'h8000_0010);
    bus.irq_req_i = 16'h0001;
    step();
    bus.irq_req_i = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_busy", 32'(bus.busy_o), 32'h0);
    mret_pulse();
    step();
    step();
    chk("rst_drain", sb.size(), 0);

    // Back-to-back: request held through ACK re-fires in the next IDLE cycle
    push_irq(32'h8000_0010);
    bus.irq_req_i = 16'h0001;
    step();
    push_ret(32'h1);
    mret_pulse();
    push_irq(32'h8000_0010);
    step();
    step();
    chk("b2b_busy", 32'(bus.busy_o), 32'h1);
    push_ret(32'h1);
    mret_pulse();
    bus.irq_req_i = '0;
    step();
    step();
    chk("b2b_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
